// File: rtl/imem_loader_if.sv
// Bus bundle between the instruction-memory loader and its surroundings.
// slave  : the loader's view (consumes Start/byte stream, produces memory writes/status)
// master : the driver's view (host/stream source and memory/fetch side observer)
interface imem_loader_if #(
    parameter int LEN_W = 16
) ();
    logic             Start;
    logic [31:0]      BaseAddr;
    logic [LEN_W-1:0] LenWords;
    logic [7:0]       ByteIn;
    logic             ByteValid;
    logic             ByteReady;
    logic             MemWe;
    logic [31:0]      MemAddr;
    logic [31:0]      MemData;
    logic             Busy;
    logic             Done;
    logic             Run;
    logic             ChkErr;

    modport slave (
        input  Start, BaseAddr, LenWords, ByteIn, ByteValid,
        output ByteReady, MemWe, MemAddr, MemData, Busy, Done, Run, ChkErr
    );

    modport master (
        output Start, BaseAddr, LenWords, ByteIn, ByteValid,
        input  ByteReady, MemWe, MemAddr, MemData, Busy, Done, Run, ChkErr
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a valid/ready byte stream into 32-bit words
// and writes them to consecutive word addresses, holding Run low while loading.
// Optional trailing checksum word enabled by defining IMEM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for Start
// LOAD    | accepting program bytes, one memory write per 4 bytes
// CHECK   | accepting the 4-byte checksum word (checksum build only)
// DONE    | load finished, Run released, Start accepted again
module imem_loader #(
    parameter int LEN_W      = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input logic           Clk,
    input logic           Reset,
    imem_loader_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_TAIL  = S_CHECK;
`else
    localparam logic [1:0] S_TAIL  = S_DONE;
`endif

    logic [1:0]       state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] word_q, word_d;
    logic [1:0]       lane_q, lane_d;
    logic [31:0]      pack_q, pack_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]      sum_q, sum_d;
    logic             chk_err_q, chk_err_d;
`endif

    logic        byte_ready;
    logic        byte_fire;
    logic [1:0]  lane_sel;
    logic [31:0] packed_now;

    // Handshake and the word as it looks with the current byte merged in
    always_comb begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        byte_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
        byte_ready = (state_q == S_LOAD);
`endif
        byte_fire  = byte_ready && bus.ByteValid;
        lane_sel   = BIG_ENDIAN ? ~lane_q : lane_q;
        packed_now = pack_q;
        packed_now[{lane_sel, 3'b000} +: 8] = bus.ByteIn;
    end

    // Next-state logic: start capture, byte packing, word writes, checksum compare
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        word_d  = word_q;
        lane_d  = lane_q;
        pack_d  = pack_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        chk_err_d = chk_err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    base_d = bus.BaseAddr & ~32'h3;
                    len_d  = bus.LenWords;
                    word_d = '0;
                    lane_d = '0;
                    pack_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d     = '0;
                    chk_err_d = 1'b0;
`endif
                    state_d = (bus.LenWords == '0) ? S_TAIL : S_LOAD;
                end
            end
            S_LOAD: begin
                if (byte_fire) begin
                    lane_d = lane_q + 2'd1;
                    pack_d = packed_now;
                    if (lane_q == 2'd3) begin
                        we_d   = 1'b1;
                        addr_d = base_q + (32'(word_q) << 2);
                        data_d = packed_now;
                        pack_d = '0;
                        word_d = word_q + LEN_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d  = sum_q + packed_now;
`endif
                        // Leave LOAD on the last handshake so ByteReady drops next cycle
                        if (word_q == len_q - LEN_W'(1)) begin
                            state_d = S_TAIL;
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (byte_fire) begin
                    lane_d = lane_q + 2'd1;
                    pack_d = packed_now;
                    if (lane_q == 2'd3) begin
                        // sum_q already includes the final program word here
                        chk_err_d = (packed_now != sum_q);
                        pack_d    = '0;
                        state_d   = S_DONE;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            word_q  <= '0;
            lane_q  <= '0;
            pack_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= '0;
            chk_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
            chk_err_q <= chk_err_d;
`endif
        end
    end

    // Output decode
    always_comb begin
        bus.ByteReady = byte_ready;
        bus.Busy      = byte_ready;
        bus.MemWe     = we_q;
        bus.MemAddr   = addr_q;
        bus.MemData   = data_q;
        bus.Done      = (state_q == S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        bus.ChkErr    = chk_err_q;
        bus.Run       = (state_q == S_DONE) && !chk_err_q;
`else
        bus.ChkErr    = 1'b0;
        bus.Run       = (state_q == S_DONE);
`endif
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (little-endian packing).
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk;
    logic rst;

    imem_loader_if #(.LEN_W(16)) bus ();

    imem_loader #(.LEN_W(16), .BIG_ENDIAN(1'b0)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    // Write log, captured just after the edge that raises MemWe
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_n = 0;

    always @(posedge clk) begin
        #1;
        if (bus.MemWe === 1'b1 && wr_n < 64) begin
            wr_addr[wr_n] = bus.MemAddr;
            wr_data[wr_n] = bus.MemData;
            wr_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic start_load(input logic [31:0] base, input logic [15:0] len);
        bus.Start    = 1'b1;
        bus.BaseAddr = base;
        bus.LenWords = len;
        @(negedge clk);
        bus.Start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        bus.ByteIn    = b;
        bus.ByteValid = 1'b1;
        while (bus.ByteReady !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(n < 20), 32'd1);
        @(negedge clk);
        bus.ByteValid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    // Sends n bytes, least significant byte of the literal first
    task automatic send_stream(input logic [63:0] bytes_lsb_first, input int n, input bit gap);
        for (int i = 0; i < n; i++) send_byte(bytes_lsb_first[8*i +: 8], gap);
    endtask

    task automatic send_sum(input logic [31:0] sum);
        if (CHK) send_stream({32'h0, sum}, 4, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"}, {26'h0, bus.ByteReady, bus.MemWe, bus.Busy, bus.Done, bus.Run, bus.ChkErr}, 32'h0);
        chk({tag, "_addr"}, bus.MemAddr, 32'h0);
        chk({tag, "_data"}, bus.MemData, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        rst           = 1'b1;
        bus.Start     = 1'b0;
        bus.BaseAddr  = '0;
        bus.LenWords  = '0;
        bus.ByteIn    = '0;
        bus.ByteValid = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic load: bytes 11..88 back-to-back at 0x100
        b0 = wr_n;
        start_load(32'h100, 16'd2);
        chk("t1_busy", 32'(bus.Busy), 32'd1);
        chk("t1_run_low", 32'(bus.Run), 32'd0);
        send_stream(64'h8877665544332211, 8, 1'b0);
        chk("t1_last_we", 32'(bus.MemWe), 32'd1);
        chk("t1_ready_drop", 32'(bus.ByteReady), 32'(CHK));
        send_sum(32'hCCAA8866);
        @(negedge clk);
        chk("t1_count", 32'(wr_n - b0), 32'd2);
        chk("t1_addr0", wr_addr[b0], 32'h100);
        chk("t1_data0", wr_data[b0], 32'h44332211);
        chk("t1_addr1", wr_addr[b0+1], 32'h104);
        chk("t1_data1", wr_data[b0+1], 32'h88776655);
        chk("t1_done", 32'(bus.Done), 32'd1);
        chk("t1_run", 32'(bus.Run), 32'd1);
        chk("t1_busy_low", 32'(bus.Busy), 32'd0);
        chk("t1_ready_low", 32'(bus.ByteReady), 32'd0);

        // Same stream with ByteValid toggling every cycle
        b0 = wr_n;
        start_load(32'h100, 16'd2);
        send_stream(64'h0000000000332211, 3, 1'b1);
        chk("t2_no_early_we", 32'(wr_n - b0), 32'd0);
        send_stream(64'h0000008877665544, 5, 1'b1);
        send_sum(32'hCCAA8866);
        @(negedge clk);
        chk("t2_count", 32'(wr_n - b0), 32'd2);
        chk("t2_addr0", wr_addr[b0], 32'h100);
        chk("t2_data0", wr_data[b0], 32'h44332211);
        chk("t2_addr1", wr_addr[b0+1], 32'h104);
        chk("t2_data1", wr_data[b0+1], 32'h88776655);

        // Len=0 from a freshly reset loader
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t3_done_clear", 32'(bus.Done), 32'd0);
        b0 = wr_n;
        start_load(32'h40, 16'd0);
        send_sum(32'h0);
        chk("t3_done", 32'(bus.Done), 32'd1);
        @(negedge clk);
        chk("t3_no_we", 32'(wr_n - b0), 32'd0);

        // Start pulsed mid-load is ignored
        b0 = wr_n;
        start_load(32'h300, 16'd2);
        send_stream(64'h0000000000002211, 2, 1'b0);
        bus.Start    = 1'b1;
        bus.BaseAddr = 32'h500;
        bus.LenWords = 16'd5;
        @(negedge clk);
        bus.Start    = 1'b0;
        chk("t4_still_busy", 32'(bus.Busy), 32'd1);
        send_stream(64'h0000887766554433, 6, 1'b0);
        send_sum(32'hCCAA8866);
        @(negedge clk);
        chk("t4_count", 32'(wr_n - b0), 32'd2);
        chk("t4_addr0", wr_addr[b0], 32'h300);
        chk("t4_addr1", wr_addr[b0+1], 32'h304);
        chk("t4_data1", wr_data[b0+1], 32'h88776655);
        chk("t4_done", 32'(bus.Done), 32'd1);

        // Reset after 6 bytes of a two-word load
        b0 = wr_n;
        start_load(32'h400, 16'd2);
        send_stream(64'h0000665544332211, 6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("t5_reset");
        rst = 1'b0;
        @(negedge clk);
        chk("t5_count", 32'(wr_n - b0), 32'd1);
        chk("t5_addr0", wr_addr[b0], 32'h400);
        chk("t5_data0", wr_data[b0], 32'h44332211);
        b0 = wr_n;
        start_load(32'h400, 16'd1);
        send_stream(64'h00000000DDCCBBAA, 4, 1'b0);
        send_sum(32'hDDCCBBAA);
        @(negedge clk);
        chk("t5_fresh_count", 32'(wr_n - b0), 32'd1);
        chk("t5_fresh_data", wr_data[b0], 32'hDDCCBBAA);

        // Address wrap past the top of the address space
        b0 = wr_n;
        start_load(32'hFFFFFFFC, 16'd2);
        send_stream(64'h0807060504030201, 8, 1'b0);
        send_sum(32'h0C0A0806);
        @(negedge clk);
        chk("t6_addr0", wr_addr[b0], 32'hFFFFFFFC);
        chk("t6_addr1", wr_addr[b0+1], 32'h00000000);
        chk("t6_data1", wr_data[b0+1], 32'h08070605);

        // Unaligned base rounds down to the word
        b0 = wr_n;
        start_load(32'h103, 16'd1);
        send_stream(64'h00000000EFBEADDE, 4, 1'b0);
        send_sum(32'hEFBEADDE);
        @(negedge clk);
        chk("t7_addr0", wr_addr[b0], 32'h100);
        chk("t7_data0", wr_data[b0], 32'hEFBEADDE);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Words 1 and 2, checksum 3 (good) then 4 (bad); checksum never written
        b0 = wr_n;
        start_load(32'h0, 16'd2);
        send_stream(64'h0000000200000001, 8, 1'b0);
        send_stream(64'h0000000000000003, 4, 1'b0);
        @(negedge clk);
        chk("c1_count", 32'(wr_n - b0), 32'd2);
        chk("c1_chkerr", 32'(bus.ChkErr), 32'd0);
        chk("c1_run", 32'(bus.Run), 32'd1);
        b0 = wr_n;
        start_load(32'h0, 16'd2);
        send_stream(64'h0000000200000001, 8, 1'b0);
        send_stream(64'h0000000000000004, 4, 1'b0);
        @(negedge clk);
        chk("c2_count", 32'(wr_n - b0), 32'd2);
        chk("c2_chkerr", 32'(bus.ChkErr), 32'd1);
        chk("c2_run", 32'(bus.Run), 32'd0);
        chk("c2_done", 32'(bus.Done), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
